hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have one clock `clk` (rising edge) and an asynchronous, active-high reset `reset`.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  async active-high reset
- RsD1, RsD2  in  5 each  source registers of the instruction in D
- RdD  in  5  destination register of the instruction in D
- RegWriteD  in  1  D instruction writes a register
- MulDivD  in  1  D instruction is a multi-cycle mul/div
- RdE  in  5  destination register of the instruction in E
- RegWriteE  in  1  E instruction writes a register
- MemReadE  in  1  E instruction is a load
- MulDivE  in  1  E instruction is a mul/div being issued to the unit this cycle
- PCSrcE  in  1  taken branch/jump resolved in E
- MulDivDoneW  in  1  mul/div result written back this cycle
- MulDivRdW  in  5  destination of that write-back
- StallF, StallD  out  1 each  hold PC / IF-ID register
- FlushD, FlushE  out  1 each  clear IF-ID / ID-EX register
- BusyMD  out  1  mul/div unit holds an outstanding operation
- StallCount  out  32  stall-cycle counter (only with HAZARD_PERF_EN)

Function
REQ-003 The block SHALL hold a 32-bit pending vector `sb`, one bit per architectural register; bit 0 SHALL always read 0.
REQ-004 On a rising edge with MulDivE=1, RegWriteE=1 and RdE!=0, the block SHALL set sb[RdE] and BusyMD.
REQ-005 On a rising edge with MulDivDoneW=1, the block SHALL clear sb[MulDivRdW] and BusyMD.
REQ-006 If set and clear address the same bit in the same cycle, set SHALL win; BusyMD SHALL be 1 after any cycle with MulDivE=1.
REQ-007 lwStall SHALL be MemReadE & RdE!=0 & (RdE==RsD1 | RdE==RsD2).
REQ-008 rawStall SHALL be 1 when any nonzero RsDx has sb[RsDx]=1, except when MulDivDoneW=1 and MulDivRdW==RsDx in the same cycle (write-back bypass).
REQ-009 wawStall SHALL be RegWriteD & RdD!=0 & sb[RdD] & !(MulDivDoneW & MulDivRdW==RdD).
REQ-010 structStall SHALL be MulDivD & BusyMD & !MulDivDoneW.
REQ-011 stall SHALL be the OR of lwStall, rawStall, wawStall and structStall.
REQ-012 Output equations SHALL be:
- StallF = StallD = stall & !PCSrcE
- FlushD = PCSrcE
- FlushE = stall | PCSrcE
REQ-013 All outputs other than BusyMD and StallCount SHALL be combinational, with zero cycles of latency from their inputs.
REQ-014 At most one mul/div operation SHALL be outstanding at a time; REQ-010 guarantees this.

Reset
REQ-015 Asserting reset SHALL asynchronously clear sb, BusyMD and StallCount to 0, including in the middle of an operation.
REQ-016 While reset is asserted, StallF, StallD, FlushD and FlushE SHALL be 0.
REQ-017 A MulDivDoneW arriving after reset SHALL be ignored; clearing already-clear bits is harmless.

Configuration
REQ-018 When macro HAZARD_PERF_EN is defined, StallCount SHALL increment by 1 on each edge where StallD=1, and SHALL saturate at 32'hFFFFFFFF with no wrap.
REQ-019 When HAZARD_PERF_EN is undefined, the StallCount port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-020 Scenario: MemReadE=1, RdE=5, RsD2=5 -> StallF=StallD=FlushE=1, FlushD=0; with RdE=0 instead -> all four outputs 0.
REQ-021 Scenario: MulDivE=1, RegWriteE=1, RdE=7 at cycle 0; RsD1=7 at cycles 1-4; MulDivDoneW=1, MulDivRdW=7 at cycle 4 -> StallD=1 in cycles 1-3, StallD=0 in cycle 4, sb[7]=0 and BusyMD=0 from cycle 5.
REQ-022 Scenario: BusyMD=1 with MulDivD=1 -> StallD=1 until the cycle MulDivDoneW=1, then issue proceeds; done and a new MulDivE to the same RdE in one cycle -> bit remains set.
REQ-023 Scenario: stall condition active together with PCSrcE=1 -> StallF=StallD=0, FlushD=FlushE=1.
REQ-024 Scenario: reset pulsed mid-operation with sb[7]=1 -> sb=0 and BusyMD=0 immediately; RsD1=7 after reset -> no stall.
REQ-025 Scenario (HAZARD_PERF_EN): StallCount preloaded to 32'hFFFFFFFE via force, three stall cycles applied -> StallCount=32'hFFFFFFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline hazard unit with a register-pending scoreboard
// for a single outstanding multi-cycle mul/div operation.
// Detects load-use, RAW and WAW against pending mul/div results, and
// structural hazards on the mul/div unit. Branch redirect overrides stalls.
// Optional feature: define HAZARD_PERF_EN to add a saturating StallCount
// output that counts decode-stall cycles.

// Per-source hazard check: load-use match and pending-register RAW match.
module hazard_src_chk (
  input  logic [4:0]  rs,
  input  logic [31:0] sb,
  input  logic [4:0]  rd_e,
  input  logic        mem_read_e,
  input  logic        md_done,
  input  logic [4:0]  md_rd_w,
  output logic        lw_hit,
  output logic        raw_hit
);
  // A write-back landing this cycle satisfies the read, so it does not stall.
  always_comb begin
    lw_hit  = mem_read_e && (rd_e != 5'd0) && (rd_e == rs);
    raw_hit = (rs != 5'd0) && sb[rs] && !(md_done && (md_rd_w == rs));
  end
endmodule

module hazard_scoreboard #(
  parameter int NUM_SRC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RsD1,
  input  logic [4:0]  RsD2,
  input  logic [4:0]  RdD,
  input  logic        RegWriteD,
  input  logic        MulDivD,
  input  logic [4:0]  RdE,
  input  logic        RegWriteE,
  input  logic        MemReadE,
  input  logic        MulDivE,
  input  logic        PCSrcE,
  input  logic        MulDivDoneW,
  input  logic [4:0]  MulDivRdW,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic        BusyMD
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] StallCount
`endif
);

  logic [31:0]                sb;
  logic [31:0]                sb_set, sb_clr, sb_nxt;
  logic [NUM_SRC-1:0][4:0]    rs;
  logic [NUM_SRC-1:0]         lw_hit, raw_hit;
  logic                       lw_stall, raw_stall, waw_stall, struct_stall, stall;

  assign rs = {RsD2, RsD1};

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      hazard_src_chk u_chk (
        .rs         (rs[g]),
        .sb         (sb),
        .rd_e       (RdE),
        .mem_read_e (MemReadE),
        .md_done    (MulDivDoneW),
        .md_rd_w    (MulDivRdW),
        .lw_hit     (lw_hit[g]),
        .raw_hit    (raw_hit[g])
      );
    end
  endgenerate

  // Scoreboard next state: clear on write-back, set on issue; set wins on
  // a same-bit collision, and r0 can never become pending.
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (MulDivE && RegWriteE && (RdE != 5'd0)) sb_set[RdE] = 1'b1;
    if (MulDivDoneW)                           sb_clr[MulDivRdW] = 1'b1;
    sb_nxt    = (sb & ~sb_clr) | sb_set;
    sb_nxt[0] = 1'b0;
  end

  // Pending vector and unit-busy flag; a new issue outranks completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb     <= '0;
      BusyMD <= 1'b0;
    end else begin
      sb <= sb_nxt;
      if (MulDivE)          BusyMD <= 1'b1;
      else if (MulDivDoneW) BusyMD <= 1'b0;
    end
  end

  // Hazard terms and pipeline control; all forced low while in reset.
  always_comb begin
    lw_stall     = |lw_hit;
    raw_stall    = |raw_hit;
    waw_stall    = RegWriteD && (RdD != 5'd0) && sb[RdD] &&
                   !(MulDivDoneW && (MulDivRdW == RdD));
    struct_stall = MulDivD && BusyMD && !MulDivDoneW;
    stall        = lw_stall || raw_stall || waw_stall || struct_stall;
    StallF       = !reset && stall && !PCSrcE;
    StallD       = !reset && stall && !PCSrcE;
    FlushD       = !reset && PCSrcE;
    FlushE       = !reset && (stall || PCSrcE);
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;

  // Saturating count of cycles in which decode was held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   stall_cnt <= '0;
    else if (StallD && (stall_cnt != '1))        stall_cnt <= stall_cnt + 32'd1;
  end

  assign StallCount = stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; define HAZARD_PERF_EN to also
// exercise the stall counter.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] RsD1, RsD2, RdD, RdE, MulDivRdW;
  logic       RegWriteD, MulDivD, RegWriteE, MemReadE, MulDivE, PCSrcE, MulDivDoneW;
  logic       StallF, StallD, FlushD, FlushE, BusyMD;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCount;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .RsD1        (RsD1),
    .RsD2        (RsD2),
    .RdD         (RdD),
    .RegWriteD   (RegWriteD),
    .MulDivD     (MulDivD),
    .RdE         (RdE),
    .RegWriteE   (RegWriteE),
    .MemReadE    (MemReadE),
    .MulDivE     (MulDivE),
    .PCSrcE      (PCSrcE),
    .MulDivDoneW (MulDivDoneW),
    .MulDivRdW   (MulDivRdW),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .BusyMD      (BusyMD)
`ifdef HAZARD_PERF_EN
    ,
    .StallCount  (StallCount)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {StallF, StallD, FlushD, FlushE}
  function automatic logic [31:0] ctl();
    return {28'd0, StallF, StallD, FlushD, FlushE};
  endfunction

  task automatic idle();
    RsD1 = 0; RsD2 = 0; RdD = 0; RegWriteD = 0; MulDivD = 0;
    RdE = 0; RegWriteE = 0; MemReadE = 0; MulDivE = 0; PCSrcE = 0;
    MulDivDoneW = 0; MulDivRdW = 0;
  endtask

  // Advance to just after the next rising edge; inputs are then changed and
  // outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    // Outputs must be quiet in reset even with hazard/branch inputs active.
    MemReadE = 1; RdE = 5; RsD2 = 5; PCSrcE = 1;
    #2;
    chk("rst_ctl", ctl(), 32'h0);
    chk("rst_busy", {31'd0, BusyMD}, 32'd0);
    step(); step();
    reset = 1'b0;
    idle();
    #1;
    chk("idle_ctl", ctl(), 32'h0);

    // Load-use hazard
    MemReadE = 1; RdE = 5; RsD2 = 5; #1;
    chk("lw_stall", ctl(), 32'hD);
    RdE = 0; RsD2 = 0; #1;
    chk("lw_rd0", ctl(), 32'h0);
    idle();

    // Mul/div RAW sequence on r7
    step();
    MulDivE = 1; RegWriteE = 1; RdE = 7; #1;
    chk("md_issue_ctl", ctl(), 32'h0);
    for (int c = 1; c <= 3; c++) begin
      step();
      idle(); RsD1 = 7; #1;
      chk($sformatf("raw_c%0d", c), {31'd0, StallD}, 32'd1);
      chk($sformatf("raw_busy_c%0d", c), {31'd0, BusyMD}, 32'd1);
    end
    step();
    MulDivDoneW = 1; MulDivRdW = 7; #1;
    chk("raw_bypass", ctl(), 32'h0);
    step();
    idle(); RsD1 = 7; RegWriteD = 1; RdD = 7; #1;
    chk("raw_cleared", ctl(), 32'h0);
    chk("busy_cleared", {31'd0, BusyMD}, 32'd0);
    idle();

    // Structural hazard and set-wins collision on r9
    MulDivE = 1; RegWriteE = 1; RdE = 9;
    step();
    idle(); MulDivD = 1; #1;
    chk("struct_stall", ctl(), 32'hD);
    RegWriteD = 1; RdD = 9; MulDivD = 0; #1;
    chk("waw_stall", {31'd0, StallD}, 32'd1);
    RdD = 0; #1;
    chk("waw_rd0", {31'd0, StallD}, 32'd0);
    RegWriteD = 0; MulDivD = 1; MulDivDoneW = 1; MulDivRdW = 9;
    MulDivE = 1; RegWriteE = 1; RdE = 9; #1;
    chk("struct_release", ctl(), 32'h0);
    step();
    idle(); RsD1 = 9; #1;
    chk("set_wins", {31'd0, StallD}, 32'd1);
    chk("set_wins_busy", {31'd0, BusyMD}, 32'd1);

    // Branch overrides stall
    RsD1 = 9; PCSrcE = 1; #1;
    chk("branch_ovr", ctl(), 32'h3);
    PCSrcE = 0;

    // Async reset mid-operation (r9 pending, busy)
    #1 reset = 1'b1; #1;
    chk("rst_mid_busy", {31'd0, BusyMD}, 32'd0);
    chk("rst_mid_ctl", ctl(), 32'h0);
    step();
    reset = 1'b0;
    idle(); MulDivDoneW = 1; MulDivRdW = 9;
    step();
    idle(); RsD1 = 9; RsD2 = 7; #1;
    chk("post_rst_raw", ctl(), 32'h0);
    chk("post_rst_busy", {31'd0, BusyMD}, 32'd0);
    idle();

`ifdef HAZARD_PERF_EN
    chk("cnt_zero", StallCount, 32'd0);
    MemReadE = 1; RdE = 3; RsD1 = 3;
    step(); step();
    chk("cnt_two", StallCount, 32'd2);
    idle();
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt;
    MemReadE = 1; RdE = 3; RsD1 = 3;
    step(); step(); step();
    chk("cnt_sat", StallCount, 32'hFFFF_FFFF);
    idle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
